// File: rtl/bus_led_segment_ctrl.sv
// CPU data-port bus controller: decodes a small LED/7-segment/switch register window,
// forwards every other access to data memory and scans an 8-digit hex display.
module bus_led_segment_ctrl #(
    parameter logic [15:0] SCAN_DIV = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_bc_addr,
    input  logic [31:0] cpu_bc_data,
    input  logic        cpu_bc_rw,
    output logic [31:0] bc_cpu_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_cat
);

    localparam logic [1:0]  RegLed     = 2'd0;
    localparam logic [1:0]  RegSegVal  = 2'd1;
    localparam logic [1:0]  RegSw      = 2'd2;
    localparam logic [1:0]  RegSegMask = 2'd3;
    localparam logic [15:0] DivLast    = SCAN_DIV - 16'd1;

    logic        periph_sel;
    logic [1:0]  reg_sel;
    logic        wr_led, wr_val, wr_mask;
    logic [31:0] seg_val_q;
    logic [7:0]  mask_q;
    logic [15:0] sw_meta_q, sw_sync_q;
    logic [15:0] div_cnt_q;
    logic [2:0]  dig_q;
    logic [3:0]  nibble;
    logic [7:0]  an_d, cat_d;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
        endcase
    endfunction

    assign periph_sel = (cpu_bc_addr[31:4] == 28'hFFFF000);
    assign reg_sel    = cpu_bc_addr[3:2];
    assign mem_addr   = cpu_bc_addr;
    assign mem_wdata  = cpu_bc_data;
    assign mem_we     = cpu_bc_rw & ~periph_sel;

    assign wr_led  = cpu_bc_rw & periph_sel & (reg_sel == RegLed);
    assign wr_val  = cpu_bc_rw & periph_sel & (reg_sel == RegSegVal);
    assign wr_mask = cpu_bc_rw & periph_sel & (reg_sel == RegSegMask);

    // Reads see the registers as they stand this cycle, so a same-cycle write is not visible.
    always_comb begin
        bc_cpu_data = mem_rdata;
        if (periph_sel) begin
            unique case (reg_sel)
                RegLed:     bc_cpu_data = {16'b0, led};
                RegSegVal:  bc_cpu_data = seg_val_q;
                RegSw:      bc_cpu_data = {16'b0, sw_sync_q};
                RegSegMask: bc_cpu_data = {24'b0, mask_q};
                default:    bc_cpu_data = mem_rdata;
            endcase
        end
    end

    always_comb begin
        nibble = seg_val_q[{dig_q, 2'b00} +: 4];
        cat_d  = hex7(nibble);
        an_d   = mask_q[dig_q] ? ~(8'b1 << dig_q) : 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            led       <= 16'h0;
            seg_val_q <= 32'h0;
            mask_q    <= 8'hFF;
        end else begin
            if (wr_led)  led       <= cpu_bc_data[15:0];
            if (wr_val)  seg_val_q <= cpu_bc_data;
            if (wr_mask) mask_q    <= cpu_bc_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sw_meta_q <= 16'h0;
            sw_sync_q <= 16'h0;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt_q <= 16'h0;
            dig_q     <= 3'd0;
            seg_an    <= 8'hFF;
            seg_cat   <= 8'hFF;
        end else begin
            if (div_cnt_q >= DivLast) begin
                div_cnt_q <= 16'h0;
                dig_q     <= dig_q + 3'd1;
            end else begin
                div_cnt_q <= div_cnt_q + 16'd1;
            end
            seg_an  <= an_d;
            seg_cat <= cat_d;
        end
    end

endmodule

// File: tb/tb_bus_led_segment_ctrl.sv
// Randomized scoreboard bench for bus_led_segment_ctrl with a cycle-count based reference model.
module tb_bus_led_segment_ctrl;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_bc_addr, cpu_bc_data, mem_rdata;
    logic        cpu_bc_rw;
    logic [31:0] bc_cpu_data, mem_addr, mem_wdata;
    logic        mem_we;
    logic [15:0] sw, led;
    logic [7:0]  seg_an, seg_cat;

    bus_led_segment_ctrl #(.SCAN_DIV(16'd4)) dut (
        .clk(clk), .rst(rst), .cpu_bc_addr(cpu_bc_addr), .cpu_bc_data(cpu_bc_data),
        .cpu_bc_rw(cpu_bc_rw), .bc_cpu_data(bc_cpu_data), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .sw(sw),
        .led(led), .seg_an(seg_an), .seg_cat(seg_cat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        we;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic [15:0] led;
        logic [7:0]  an;
        logic [7:0]  cat;
    } exp_t;

    exp_t exp_q[$];
    int   n_vectors = 0;
    int   n_miscompares = 0;

    logic [7:0]  hex_tab [16];
    logic [15:0] m_led, m_sw1, m_sw2;
    logic [31:0] m_val;
    logic [7:0]  m_mask, m_an, m_cat;
    int          m_n;
    bit          m_ok = 0;

    function automatic bit is_periph(input logic [31:0] a);
        return a >= 32'hFFFF0000 && a <= 32'hFFFF000F;
    endfunction

    // Reference model of one rising edge, using the inputs held during the ending cycle.
    task automatic model_edge();
        int d;
        int nib;
        logic [7:0] an;
        if (rst === 1'b0) begin
            m_led = 0; m_val = 0; m_mask = 8'hFF; m_sw1 = 0; m_sw2 = 0;
            m_an = 8'hFF; m_cat = 8'hFF; m_n = 0; m_ok = 1;
        end else if (m_ok) begin
            d   = (m_n / SD) % 8;
            nib = int'((m_val >> (4 * d)) & 32'hF);
            an  = 8'hFF;
            if (m_mask[d]) an[d] = 1'b0;
            m_an  = an;
            m_cat = hex_tab[nib];
            m_n++;
            if (cpu_bc_rw && is_periph(cpu_bc_addr)) begin
                case ((cpu_bc_addr - 32'hFFFF0000) / 4)
                    0: m_led = cpu_bc_data[15:0];
                    1: m_val = cpu_bc_data;
                    3: m_mask = cpu_bc_data[7:0];
                    default: ;
                endcase
            end
            m_sw2 = m_sw1;
            m_sw1 = sw;
        end
    endtask

    task automatic step(input logic r, input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic [15:0] s, input logic [31:0] rd);
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        rst = r; cpu_bc_addr = a; cpu_bc_data = d; cpu_bc_rw = w; sw = s; mem_rdata = rd;
        if (m_ok) begin
            e.rd = rd;
            if (is_periph(a)) begin
                case ((a - 32'hFFFF0000) / 4)
                    0: e.rd = {16'b0, m_led};
                    1: e.rd = m_val;
                    2: e.rd = {16'b0, m_sw2};
                    default: e.rd = {24'b0, m_mask};
                endcase
            end
            e.we = w && !is_periph(a);
            e.maddr = a; e.mwd = d;
            e.led = m_led; e.an = m_an; e.cat = m_cat;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n, input logic [15:0] s);
        for (int i = 0; i < n; i++) step(1'b1, 32'h00000100, $urandom, 1'b0, s, $urandom);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vectors++;
            if (bc_cpu_data !== e.rd) begin
                n_miscompares++;
                $display("FAIL rdata t=%0t got %h want %h", $time, bc_cpu_data, e.rd);
            end
            if (mem_we !== e.we) begin
                n_miscompares++;
                $display("FAIL mem_we t=%0t got %b want %b", $time, mem_we, e.we);
            end
            if (mem_addr !== e.maddr || mem_wdata !== e.mwd) begin
                n_miscompares++;
                $display("FAIL mem_pass t=%0t got %h/%h want %h/%h", $time, mem_addr,
                         mem_wdata, e.maddr, e.mwd);
            end
            if (led !== e.led) begin
                n_miscompares++;
                $display("FAIL led t=%0t got %h want %h", $time, led, e.led);
            end
            if (seg_an !== e.an) begin
                n_miscompares++;
                $display("FAIL seg_an t=%0t got %h want %h", $time, seg_an, e.an);
            end
            if (seg_cat !== e.cat) begin
                n_miscompares++;
                $display("FAIL seg_cat t=%0t got %h want %h", $time, seg_cat, e.cat);
            end
        end
    end

    initial begin
        logic [31:0] a;
        hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        rst = 1'b0; cpu_bc_addr = 0; cpu_bc_data = 0; cpu_bc_rw = 0; sw = 0; mem_rdata = 0;

        // Reset, then a full scan frame plus change with display blank.
        step(1'b0, 32'h0, 32'h0, 1'b0, 16'h0, 32'h0);
        idle(40, 16'h0);
        // Segment value write, read-back, then a full frame of digits.
        step(1'b1, 32'hFFFF0004, 32'h1234ABCD, 1'b1, 16'h0, 32'h0);
        step(1'b1, 32'hFFFF0004, 32'h0, 1'b0, 16'h0, 32'h0);
        idle(34, 16'h0);
        // LED write, discarded switch write, switch synchronizer latency.
        step(1'b1, 32'hFFFF0000, 32'h0000A5A5, 1'b1, 16'h0, 32'h0);
        step(1'b1, 32'hFFFF0008, 32'h0000DEAD, 1'b1, 16'h0, 32'h0);
        step(1'b1, 32'hFFFF0008, 32'h0, 1'b0, 16'h0F0F, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'hFFFF0008, 32'h0, 1'b0, 16'h0F0F, 32'h0);
        // Mask to digits 0 and 2 only.
        step(1'b1, 32'hFFFF000C, 32'h00000005, 1'b1, 16'h0F0F, 32'h0);
        idle(34, 16'h0F0F);
        // Memory pass-through, then reset colliding with an LED write.
        step(1'b1, 32'h00000010, 32'h87654321, 1'b1, 16'h0F0F, 32'h0);
        step(1'b1, 32'h00000010, 32'h0, 1'b0, 16'h0F0F, 32'hCAFEF00D);
        step(1'b0, 32'hFFFF0000, 32'h0000FFFF, 1'b1, 16'h0F0F, 32'h0);
        idle(6, 16'h0F0F);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) != 0) a = {28'hFFFF000, 4'($urandom)};
            else a = $urandom;
            step(($urandom_range(199) == 0) ? 1'b0 : 1'b1, a, $urandom, 1'($urandom),
                 16'($urandom), $urandom);
        end

        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_miscompares++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
